// File: rtl/memory_responder.sv
// Word-addressed RAM responder for the MAR/MDR interface; optional MEM_BOUNDS_CHECK_EN adds mem_err.
// Latency: mem_done high WAIT_STATES+1 edges after the accepting edge, for one cycle.
// Backpressure: only a rising Read/Write in IDLE starts an access; strobes in BUSY/DONE are ignored.
module memory_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        Read,
   input  logic        Write,
   input  logic [31:0] MARdataout,
   input  logic [31:0] MDRdataout,
   output logic [31:0] Mdatain,
   output logic        mem_busy,
   output logic        mem_done
`ifdef MEM_BOUNDS_CHECK_EN
   ,
   output logic        mem_err
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_nxt;
   logic                req, req_prev;
   logic                accept, access;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   addr;
   logic [31:0]         wdata;
   logic                op_wr;
   logic                oob;
   logic [31:0]         ram [0:(1<<ADDR_W)-1];

   assign req = Read | Write;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      access    = 1'b0;
      mem_busy  = 1'b0;
      mem_done  = 1'b0;
      case (state)
         IDLE: begin
            if (req && !req_prev) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            mem_busy = 1'b1;
            if (cnt == 4'd0) begin
               access    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            mem_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= IDLE;
         req_prev <= 1'b0;
         cnt      <= 4'd0;
         addr     <= '0;
         wdata    <= 32'd0;
         op_wr    <= 1'b0;
         Mdatain  <= 32'd0;
      end else begin
         state    <= state_nxt;
         req_prev <= req;
         if (accept) begin
            addr  <= MARdataout[ADDR_W-1:0];
            wdata <= MDRdataout;
            op_wr <= Write;
            cnt   <= 4'(WAIT_STATES);
         end else if (state == BUSY && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access && !op_wr)
            Mdatain <= oob ? 32'hDEADBEEF : ram[addr];
      end
   end

   // RAM survives reset; a reset mid-access leaves state IDLE so no write fires.
   always_ff @(posedge clk) begin
      if (access && op_wr && !oob)
         ram[addr] <= wdata;
   end

`ifdef MEM_BOUNDS_CHECK_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         oob <= 1'b0;
      else if (accept)
         oob <= |MARdataout[31:ADDR_W];
   end

   assign mem_err = (state == DONE) && oob;
`else
   logic unused_hi;

   // Upper address bits alias onto the low ADDR_W bits.
   assign oob       = 1'b0;
   assign unused_hi = |MARdataout[31:ADDR_W];
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: vector table through a scoreboard, plus held-strobe, reset and zero-wait sequences.
module tb_memory_responder;

   localparam int WS = 2;
`ifdef MEM_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        Read = 1'b0, Write = 1'b0;
   logic [31:0] MARdataout = 32'd0, MDRdataout = 32'd0;
   logic [31:0] Mdatain;
   logic        mem_busy, mem_done;
   logic        r1 = 1'b0, w1 = 1'b0;
   logic [31:0] mar1 = 32'd0, mdr1 = 32'd0;
   logic [31:0] mdat1;
   logic        busy1, done1;
`ifdef MEM_BOUNDS_CHECK_EN
   logic        mem_err, unused_err1;
`endif

   always #5 clk = ~clk;

   memory_responder #(.ADDR_W(9), .WAIT_STATES(WS)) dut (
      .clk(clk), .clr(clr), .Read(Read), .Write(Write),
      .MARdataout(MARdataout), .MDRdataout(MDRdataout),
      .Mdatain(Mdatain), .mem_busy(mem_busy), .mem_done(mem_done)
`ifdef MEM_BOUNDS_CHECK_EN
      , .mem_err(mem_err)
`endif
   );

   memory_responder #(.ADDR_W(9), .WAIT_STATES(0)) dut0 (
      .clk(clk), .clr(clr), .Read(r1), .Write(w1),
      .MARdataout(mar1), .MDRdataout(mdr1),
      .Mdatain(mdat1), .mem_busy(busy1), .mem_done(done1)
`ifdef MEM_BOUNDS_CHECK_EN
      , .mem_err(unused_err1)
`endif
   );

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_mdat;
      bit          exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] mdat;
      bit          err;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, got, exp, $time);
   endtask

   // Completion monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (clr && mem_done) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got mem_done=1 required no pending access (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_mdatain", Mdatain, e.mdat);
`ifdef MEM_BOUNDS_CHECK_EN
            check("sb_mem_err", {31'd0, mem_err}, {31'd0, e.err});
`endif
         end
      end
   end

   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_mdat, input bit exp_err);
      int busy_n;
      bit got_done;
      @(negedge clk);
      Read = rd; Write = wr; MARdataout = addr; MDRdataout = data;
      sb.push_back('{exp_mdat, exp_err});
      @(posedge clk);
      busy_n = 0;
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(negedge clk);
         Read = 1'b0; Write = 1'b0;
         MARdataout = $urandom; MDRdataout = $urandom;
         if (mem_done) got_done = 1'b1;
         else if (mem_busy) busy_n++;
      end
      check("done_seen", {31'd0, got_done}, 32'd1);
      check("busy_cycles", busy_n, WS + 1);
      @(negedge clk);
      check("done_one_cycle", {31'd0, mem_done}, 32'd0);
   endtask

   task automatic access_ws0(input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_mdat);
      int busy_n;
      bit got_done;
      @(negedge clk);
      r1 = !wr; w1 = wr; mar1 = addr; mdr1 = data;
      @(posedge clk);
      busy_n = 0;
      got_done = 1'b0;
      for (int i = 0; i < 10 && !got_done; i++) begin
         @(negedge clk);
         r1 = 1'b0; w1 = 1'b0;
         if (done1) got_done = 1'b1;
         else if (busy1) busy_n++;
      end
      check("ws0_done_seen", {31'd0, got_done}, 32'd1);
      check("ws0_busy_cycles", busy_n, 1);
      check("ws0_mdatain", mdat1, exp_mdat);
      @(negedge clk);
   endtask

   initial begin
      vec_t vecs[13];
      int   dones;

      vecs[0]  = '{1'b0, 1'b1, 32'h12,   32'h00001234, 32'h0,          1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h12,   32'h0,        32'h00001234,   1'b0};
      vecs[2]  = '{1'b1, 1'b1, 32'h5,    32'hA5A5A5A5, 32'h00001234,   1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h5,    32'h0,        32'hA5A5A5A5,   1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h7,    32'h77,       32'hA5A5A5A5,   1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h8,    32'h88,       32'hA5A5A5A5,   1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h7,    32'h0,        32'h77,         1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'h0,    32'h11110000, 32'h77,         1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h200,  32'h0,        BC ? 32'hDEADBEEF : 32'h11110000, BC};
      vecs[9]  = '{1'b0, 1'b1, 32'h200,  32'h22220000, BC ? 32'hDEADBEEF : 32'h11110000, BC};
      vecs[10] = '{1'b1, 1'b0, 32'h0,    32'h0,        BC ? 32'h11110000 : 32'h22220000, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'h1012, 32'h0,        BC ? 32'hDEADBEEF : 32'h00001234, BC};
      vecs[12] = '{1'b0, 1'b1, 32'h20,   32'h0BADF00D, BC ? 32'hDEADBEEF : 32'h00001234, 1'b0};

      #1 clr = 1'b0;
      #1;
      check("rst_busy", {31'd0, mem_busy}, 32'd0);
      check("rst_done", {31'd0, mem_done}, 32'd0);
      check("rst_mdatain", Mdatain, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) clr = 1'b1;

      foreach (vecs[i])
         do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_mdat, vecs[i].exp_err);

      // Held Read yields one access; dropping for a cycle re-arms it.
      @(negedge clk);
      Read = 1'b1; MARdataout = 32'h12;
      sb.push_back('{32'h00001234, 1'b0});
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (mem_done) dones++;
      end
      check("held_read_dones", dones, 1);
      Read = 1'b0;
      @(negedge clk);
      Read = 1'b1;
      sb.push_back('{32'h00001234, 1'b0});
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (mem_done) dones++;
      end
      check("rearm_dones", dones, 1);
      Read = 1'b0;
      @(negedge clk);

      // Reset in BUSY abandons the overwrite of 0x20.
      Write = 1'b1; MARdataout = 32'h20; MDRdataout = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      Write = 1'b0;
      check("busy_before_rst", {31'd0, mem_busy}, 32'd1);
      #2 clr = 1'b0;
      #1;
      check("midrst_busy", {31'd0, mem_busy}, 32'd0);
      check("midrst_done", {31'd0, mem_done}, 32'd0);
      check("midrst_mdatain", Mdatain, 32'd0);
      @(posedge clk);
      @(negedge clk) clr = 1'b1;
      do_access(1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

      access_ws0(1'b1, 32'h3, 32'h55AA00FF, 32'h0);
      access_ws0(1'b0, 32'h3, 32'h0,        32'h55AA00FF);

      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end of the test");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR memory interface.
- Samples Read/Write strobes plus MAR address and MDR write data, and serves the request from an internal word-addressed RAM after a programmable number of wait states.
- Returns read data on Mdatain with a one-cycle mem_done pulse.
- Sits beside the datapath and is driven by the control sequencer's Read/Write strobes.

Parameters:
- ADDR_W, 9: RAM index width; depth = 2**ADDR_W 32-bit words, indexed by MARdataout[ADDR_W-1:0].
- WAIT_STATES, 2: extra cycles spent in BUSY before the access completes; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  asynchronous active-low reset.
- Read  input  1  read request strobe, level, held by the requester.
- Write  input  1  write request strobe, level, held by the requester.
- MARdataout  input  32  word address.
- MDRdataout  input  32  write data.
- Mdatain  output  32  read data to MDR; registered.
- mem_busy  output  1  high while a request is in progress (BUSY state).
- mem_done  output  1  one-cycle completion pulse (DONE state).

Behaviour:
- Reset (clr=0, asynchronous): state IDLE; Mdatain=0, mem_busy=0, mem_done=0, wait counter=0, req_prev=0. RAM contents are not cleared.
- Request detection:
  - req = Read|Write.
  - req_prev registers req every cycle.
  - A request is accepted only in IDLE, on an edge where req=1 and req_prev=0 (rising strobe).
  - A strobe held high across completion does not start a second access. The requester must drop the strobe for at least one cycle to re-arm.
- Accept edge:
  - Latch address = MARdataout[ADDR_W-1:0], data = MDRdataout, op = Write (Write has priority when Read and Write are both high).
  - Load counter = WAIT_STATES and go to BUSY.
  - Later changes on MAR/MDR/strobes do not affect the in-flight access.
- BUSY:
  - mem_busy=1.
  - At each edge: if counter != 0, decrement; else perform the access and go to DONE.
  - Write access: RAM[addr] <= data; Mdatain unchanged.
  - Read access: Mdatain <= RAM[addr].
- DONE:
  - mem_done=1, mem_busy=0, for exactly one cycle; then IDLE.
  - Read data is valid on Mdatain in the DONE cycle and holds until the next completed read.
- Latency: mem_done is high in the cycle beginning WAIT_STATES+1 edges after the accept edge. With WAIT_STATES=0, done is high in the cycle after the first edge following accept.
- Strobes in BUSY or DONE are ignored, but req_prev still tracks them.
- Reset mid-operation: the pending access is abandoned and the RAM is unchanged. Because req_prev resets to 0, a strobe held through reset is accepted once after clr returns high.
- Address wrap: upper MAR bits are ignored (aliasing), unless the optional feature is enabled.

Optional Feature:
- Macro MEM_BOUNDS_CHECK_EN.
- When defined:
  - Adds output mem_err (1 bit, reset 0).
  - The accept edge also latches oob = |MARdataout[31:ADDR_W].
  - At completion of an oob access: the write is suppressed, a read loads Mdatain=32'hDEADBEEF, and mem_err=1 in the DONE cycle only (0 otherwise).
  - Timing is identical to a normal access.
- When not defined: no mem_err port; out-of-range addresses alias onto the low ADDR_W bits.

Test Plan:
1. WAIT_STATES=2, Write pulse with MAR=0x12, MDR=0x00001234, followed by a Read of 0x12 -> busy for 3 cycles after each accept, done pulse 1 cycle, Mdatain=0x00001234 in the read's DONE cycle.
2. Read held high for 10 cycles at MAR=0x12 -> exactly one done pulse. Drop Read 1 cycle, reassert -> second done pulse, same data.
3. Read and Write both rising, MAR=0x5, MDR=0xA5A5A5A5 -> RAM[5]=0xA5A5A5A5, Mdatain unchanged. A subsequent read of 5 returns 0xA5A5A5A5.
4. Write 0x0BADF00D to 0x20, then Write 0xFFFFFFFF to 0x20 with clr pulsed low during BUSY -> busy/done drop to 0 asynchronously, Mdatain=0, and a later read of 0x20 returns 0x0BADF00D.
5. Read accepted at MAR=0x7 (RAM[7]=0x77), MAR changed to 0x8 during BUSY -> Mdatain=0x77. WAIT_STATES=0 run -> done in the cycle after the first post-accept edge.
6. MEM_BOUNDS_CHECK_EN defined, Read at MAR=0x00000200 (ADDR_W=9) -> mem_err=1 with done, Mdatain=0xDEADBEEF; Write there leaves RAM[0] unchanged. Macro undefined -> same read returns RAM[0].
